// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES decryption engine, UNROLL Feistel rounds per clock.
// Subkeys are applied in reverse order by right-rotating the C/D key halves.
// Optional feature macro: DES_ENC_MODE_EN adds a wEncrypt input that selects
// forward key order (left rotation before every round), giving DES encryption.
module des_decrypt_iter #(
   parameter int UNROLL = 1
) (
   input  logic        wClk,
   input  logic        wReset,
   input  logic        wInValid,
   output logic        wInReady,
   input  logic [63:0] wCipherIn,
   input  logic [63:0] wKeyIn,
`ifdef DES_ENC_MODE_EN
   input  logic        wEncrypt,
`endif
   output logic        wOutValid,
   input  logic        wOutReady,
   output logic [63:0] wPlainOut,
   output logic        wBusy
);

   generate
      if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
         $error("des_decrypt_iter: UNROLL must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   // Permutation tables in DES 1-based bit numbering (bit 1 = MSB).
   localparam int unsigned IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
   localparam int unsigned E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int unsigned P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // S-boxes S1..S8, one 256-bit row-major table each (row 0 col 0 leftmost).
   // S1 lands in SBOX[7], S8 in SBOX[0]; entry n of a box is at index 63-n.
   localparam logic [7:0][63:0][3:0] SBOX = {
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
      return y;
   endfunction

   // Final permutation is the inverse of IP: output bit IP_T[i] takes input bit i+1.
   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(64 - IP_T[i])] = x[6'(63 - i)];
      return y;
   endfunction

   function automatic logic [47:0] e_expand(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
      return y;
   endfunction

   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
      return y;
   endfunction

   // Six-bit group j: outer bits [5],[0] pick the row, inner bits [4:1] the column.
   function automatic logic [31:0] sbox_sub(input logic [47:0] x);
      logic [31:0] y;
      logic [5:0]  b;
      y = '0;
      for (int j = 0; j < 8; j++) begin
         b = 6'(x >> (42 - 6 * j));
         y = {y[27:0], SBOX[3'(7 - j)][6'(63 - {b[5], b[0], b[4:1]})]};
      end
      return y;
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
      return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
      return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   state_t      state_q, state_n;
   logic [4:0]  rnd_q;
   logic [31:0] l_q, r_q, l_n, r_n;
   logic [27:0] c_q, d_q, c_n, d_n;
   logic [63:0] pt_q;
   logic        enc_q;

`ifndef DES_ENC_MODE_EN
   assign enc_q = 1'b0;
`endif

   assign wPlainOut = pt_q;

   // Unrolled Feistel chain: UNROLL rounds starting after round rnd_q.
   always_comb begin : round_chain
      logic [31:0] f;
      logic [31:0] t;
      int          k;
      c_n = c_q;
      d_n = d_q;
      l_n = l_q;
      r_n = r_q;
      f   = '0;
      t   = '0;
      k   = 0;
      for (int u = 0; u < UNROLL; u++) begin
         k = int'(rnd_q) + u + 1;
         if (enc_q) begin
            c_n = rotl28(c_n, (k == 1) || (k == 2) || (k == 9) || (k == 16));
            d_n = rotl28(d_n, (k == 1) || (k == 2) || (k == 9) || (k == 16));
         end else if (k >= 2) begin
            c_n = rotr28(c_n, (k == 2) || (k == 9) || (k == 16));
            d_n = rotr28(d_n, (k == 2) || (k == 9) || (k == 16));
         end
         f   = p_perm(sbox_sub(e_expand(r_n) ^ pc2_perm({c_n, d_n})));
         t   = l_n;
         l_n = r_n;
         r_n = t ^ f;
      end
   end

   // State register.
   always_ff @(posedge wClk or posedge wReset) begin
      if (wReset) state_q <= IDLE;
      else        state_q <= state_n;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_n   = state_q;
      wInReady  = 1'b0;
      wOutValid = 1'b0;
      wBusy     = 1'b0;
      case (state_q)
         IDLE: begin
            wInReady = 1'b1;
            if (wInValid) state_n = ROUND;
         end
         ROUND: begin
            wBusy = 1'b1;
            if (rnd_q == 5'd16) state_n = DONE;
         end
         DONE: begin
            wOutValid = 1'b1;
            if (wOutReady) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Job capture, round iteration and plaintext capture on entry to DONE.
   always_ff @(posedge wClk or posedge wReset) begin
      if (wReset) begin
         rnd_q <= '0;
         l_q   <= '0;
         r_q   <= '0;
         c_q   <= '0;
         d_q   <= '0;
         pt_q  <= '0;
`ifdef DES_ENC_MODE_EN
         enc_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (wInValid) begin
                  {l_q, r_q} <= ip_perm(wCipherIn);
                  {c_q, d_q} <= pc1_perm(wKeyIn);
                  rnd_q      <= '0;
`ifdef DES_ENC_MODE_EN
                  enc_q      <= wEncrypt;
`endif
               end
            end
            ROUND: begin
               if (rnd_q == 5'd16) begin
                  pt_q <= fp_perm({r_q, l_q});
               end else begin
                  l_q   <= l_n;
                  r_q   <= r_n;
                  c_q   <= c_n;
                  d_q   <= d_n;
                  rnd_q <= rnd_q + 5'(UNROLL);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// tb_des_decrypt_iter: directed-vector bench for des_decrypt_iter with
// UNROLL = 1, 2 and 4 instances sharing one stimulus stream.
module tb_des_decrypt_iter;

   localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
   localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
   localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
   localparam logic [63:0] CT2 = 64'h0000000000000000;
   localparam logic [63:0] PT2 = 64'h8787878787878787;
   localparam logic [63:0] JUNK = 64'hDEADBEEF0BADF00D;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] cipher;
   logic [63:0] key;
`ifdef DES_ENC_MODE_EN
   logic        encrypt;
`endif
   logic        in_ready [3];
   logic        ov [3];
   logic        busy [3];
   logic [63:0] pt [3];

   int checks = 0;
   int errors = 0;
   int lat [3];

   always #5 clk = ~clk;

   des_decrypt_iter #(.UNROLL(1)) dut1 (
      .wClk(clk), .wReset(rst), .wInValid(in_valid), .wInReady(in_ready[0]),
      .wCipherIn(cipher), .wKeyIn(key),
`ifdef DES_ENC_MODE_EN
      .wEncrypt(encrypt),
`endif
      .wOutValid(ov[0]), .wOutReady(out_ready), .wPlainOut(pt[0]), .wBusy(busy[0]));

   des_decrypt_iter #(.UNROLL(2)) dut2 (
      .wClk(clk), .wReset(rst), .wInValid(in_valid), .wInReady(in_ready[1]),
      .wCipherIn(cipher), .wKeyIn(key),
`ifdef DES_ENC_MODE_EN
      .wEncrypt(encrypt),
`endif
      .wOutValid(ov[1]), .wOutReady(out_ready), .wPlainOut(pt[1]), .wBusy(busy[1]));

   des_decrypt_iter #(.UNROLL(4)) dut4 (
      .wClk(clk), .wReset(rst), .wInValid(in_valid), .wInReady(in_ready[2]),
      .wCipherIn(cipher), .wKeyIn(key),
`ifdef DES_ENC_MODE_EN
      .wEncrypt(encrypt),
`endif
      .wOutValid(ov[2]), .wOutReady(out_ready), .wPlainOut(pt[2]), .wBusy(busy[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a job at a negedge, let it be accepted, then scramble the inputs.
   task automatic start_job(input logic [63:0] ct, input logic [63:0] k);
      chk("ready_idle", 64'(in_ready[0]), 64'd1);
      cipher   = ct;
      key      = k;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cipher   = JUNK;
      key      = ~k;
      chk("ready_low_round", 64'(in_ready[0]), 64'd0);
      chk("busy_round", 64'(busy[0]), 64'd1);
   endtask

   // Count clocks from the accept edge until each instance raises wOutValid.
   task automatic wait_done(input int max_c);
      int c;
      c   = 0;
      lat = '{0, 0, 0};
      while (c < max_c && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
         @(posedge clk);
         @(negedge clk);
         c++;
         in_valid = (c == 3);
         for (int i = 0; i < 3; i++) if (lat[i] == 0 && ov[i]) lat[i] = c;
      end
      in_valid = 1'b0;
   endtask

   // Hold the output for 'hold' cycles with junk requests, then hand it off.
   task automatic finish_job(input logic [63:0] exp, input int hold);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         cipher   = JUNK ^ 64'(i);
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", 64'(ov[0]), 64'd1);
         chk("hold_ready", 64'(in_ready[0]), 64'd0);
         chk("hold_data", pt[0], exp);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", 64'(ov[0]), 64'd0);
      chk("ready_back", 64'(in_ready[0]), 64'd1);
      chk("data_kept", pt[0], exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, acc2, second, rdy18;
      logic [63:0] r1, r2;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cipher    = '0;
      key       = '0;
`ifdef DES_ENC_MODE_EN
      encrypt   = 1'b0;
`endif
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", 64'(in_ready[i]), 64'd1);
         chk("rst_valid", 64'(ov[i]), 64'd0);
         chk("rst_busy", 64'(busy[i]), 64'd0);
         chk("rst_data", pt[i], 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Classic vector on all three unroll factors.
      start_job(CT1, K1);
      wait_done(40);
      chk("lat_u1_v1", 64'(lat[0]), 64'd17);
      chk("lat_u2_v1", 64'(lat[1]), 64'd9);
      chk("lat_u4_v1", 64'(lat[2]), 64'd5);
      for (int i = 0; i < 3; i++) chk("pt_v1", pt[i], PT1);
      finish_job(PT1, 0);

      // Second vector with ten cycles of output backpressure.
      start_job(CT2, K2);
      wait_done(40);
      chk("lat_u1_v2", 64'(lat[0]), 64'd17);
      chk("lat_u2_v2", 64'(lat[1]), 64'd9);
      chk("lat_u4_v2", 64'(lat[2]), 64'd5);
      for (int i = 0; i < 3; i++) chk("pt_v2", pt[i], PT2);
      finish_job(PT2, 10);

      // Asynchronous reset in the middle of a job.
      start_job(CT1, K1);
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", 64'(in_ready[0]), 64'd1);
      chk("midrst_valid", 64'(ov[0]), 64'd0);
      chk("midrst_busy", 64'(busy[0]), 64'd0);
      chk("midrst_data", pt[0], 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_job(CT1, K1);
      wait_done(40);
      chk("lat_after_rst", 64'(lat[0]), 64'd17);
      chk("pt_after_rst", pt[0], PT1);
      finish_job(PT1, 0);

      // Back-to-back jobs with wInValid held high and wOutReady=1.
      first = 0; acc2 = 0; second = 0; rdy18 = 0;
      r1 = '0; r2 = '0;
      out_ready = 1'b1;
      cipher    = CT1;
      key       = K1;
      in_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cipher = CT2;
      key    = K2;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 18) rdy18 = int'(in_ready[0]);
         if (first == 0 && ov[0]) begin
            first = c;
            r1    = pt[0];
         end else if (first != 0 && acc2 == 0 && busy[0]) begin
            acc2     = c;
            in_valid = 1'b0;
         end else if (acc2 != 0 && ov[0]) begin
            second = c;
            r2     = pt[0];
            break;
         end
      end
      in_valid = 1'b0;
      chk("b2b_first_lat", 64'(first), 64'd17);
      chk("b2b_first_pt", r1, PT1);
      chk("b2b_idle_ready", 64'(rdy18), 64'd1);
      chk("b2b_accept2", 64'(acc2), 64'd19);
      chk("b2b_second_lat", 64'(second), 64'd36);
      chk("b2b_second_pt", r2, PT2);
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

`ifdef DES_ENC_MODE_EN
      // Forward key order produces encryption with the same timing.
      encrypt = 1'b1;
      start_job(PT1, K1);
      encrypt = 1'b0;
      wait_done(40);
      chk("enc_lat", 64'(lat[0]), 64'd17);
      for (int i = 0; i < 3; i++) chk("enc_ct", pt[i], CT1);
      finish_job(CT1, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
